// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the handshaked pipeline stage register and its perf counter.
package pipe_stage_skid_pkg;

  localparam int STAGE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } stage_state_e;

  // The stage keeps no separate state register: occupancy is the state.
  function automatic stage_state_e stage_state(input logic main_v, input logic skid_v);
    if (skid_v)      return ST_SKID;
    else if (main_v) return ST_FULL;
    else             return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
  import pipe_stage_skid_pkg::*;
#(
  parameter int W = STAGE_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer, flush and stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = STAGE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_cnt
);

  logic stall_inc;

  generate
    if (SKID != 0) begin : g_skid
      logic             main_v_q, main_v_d;
      logic             skid_v_q, skid_v_d;
      logic             rdy_q;
      logic             up_fire;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      stage_state_e     state;

      assign up_fire = up_valid && rdy_q;

      always_comb begin
        state    = stage_state(main_v_q, skid_v_q);
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        case (state)
          ST_EMPTY: begin
            if (up_fire) begin
              main_v_d = 1'b1;
              main_d   = up_data;
            end
          end
          ST_FULL: begin
            if (up_fire && down_ready) begin
              main_d = up_data;
            end else if (up_fire) begin
              skid_v_d = 1'b1;
              skid_d   = up_data;
            end else if (down_ready) begin
              main_v_d = 1'b0;
            end
          end
          ST_SKID: begin
            if (down_ready) begin
              main_d   = skid_q;
              skid_v_d = 1'b0;
            end
          end
          default: begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
          end
        endcase
        // A down_fire in the flush cycle has already left; nothing is replayed.
        if (flush) begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      end

      // Stage boundary: control flops (reset) and payload flops (no reset).
      always_ff @(posedge clk) begin
        if (rst) begin
          main_v_q <= 1'b0;
          skid_v_q <= 1'b0;
          rdy_q    <= 1'b1;
        end else begin
          main_v_q <= main_v_d;
          skid_v_q <= skid_v_d;
          rdy_q    <= !skid_v_d;
        end
      end

      always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
      end

      assign up_ready   = rdy_q;
      assign down_valid = main_v_q;
      assign down_data  = main_q;
    end else begin : g_reg
      logic             main_v_q, main_v_d;
      logic             up_fire;
      logic [WIDTH-1:0] main_q, main_d;

      assign up_ready = !main_v_q || down_ready;
      assign up_fire  = up_valid && up_ready;

      always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        if (up_fire) begin
          main_v_d = 1'b1;
          main_d   = up_data;
        end else if (down_ready) begin
          main_v_d = 1'b0;
        end
        if (flush) main_v_d = 1'b0;
      end

      // Stage boundary: single register, combinational ready.
      always_ff @(posedge clk) begin
        if (rst) main_v_q <= 1'b0;
        else     main_v_q <= main_v_d;
      end

      always_ff @(posedge clk) begin
        main_q <= main_d;
      end

      assign down_valid = main_v_q;
      assign down_data  = main_q;
    end
  endgenerate

  assign stall_inc = down_valid && !down_ready && !flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall_inc),
    .clr(clr_stats),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised bench: three stage variants checked against a FIFO-occupancy reference model.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush      [N];
  logic        up_valid   [N];
  logic        up_ready   [N];
  logic [31:0] up_data    [N];
  logic        down_valid [N];
  logic        down_ready [N];
  logic [31:0] down_data  [N];
  logic        clr_stats  [N];
  logic [15:0] st         [N];
  logic [3:0]  st_small;

  // Reference model: stage = FIFO of capacity cap, upstream = source queue.
  logic [31:0] mq  [N][$];
  logic [31:0] src [N][$];
  int          mst [N];
  int          cap [N] = '{2, 1, 2};
  int          mx  [N] = '{65535, 65535, 15};

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush[0]), .up_valid(up_valid[0]), .up_ready(up_ready[0]),
    .up_data(up_data[0]), .down_valid(down_valid[0]), .down_ready(down_ready[0]),
    .down_data(down_data[0]), .clr_stats(clr_stats[0]), .stall_cnt(st[0]));

  pipe_stage_skid #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_reg (
    .clk(clk), .rst(rst), .flush(flush[1]), .up_valid(up_valid[1]), .up_ready(up_ready[1]),
    .up_data(up_data[1]), .down_valid(down_valid[1]), .down_ready(down_ready[1]),
    .down_data(down_data[1]), .clr_stats(clr_stats[1]), .stall_cnt(st[1]));

  pipe_stage_skid #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .flush(flush[2]), .up_valid(up_valid[2]), .up_ready(up_ready[2]),
    .up_data(up_data[2]), .down_valid(down_valid[2]), .down_ready(down_ready[2]),
    .down_data(down_data[2]), .clr_stats(clr_stats[2]), .stall_cnt(st_small));

  assign st[2] = {12'd0, st_small};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_all(input logic dr, input logic fl, input logic cl);
    for (int i = 0; i < N; i++) begin
      down_ready[i] = dr;
      flush[i]      = fl;
      clr_stats[i]  = cl;
    end
  endtask

  task automatic push_all(input logic [31:0] v);
    for (int i = 0; i < N; i++) src[i].push_back(v);
  endtask

  task automatic step(input bit do_chk);
    bit          er [N];
    bit          fu, fd;
    int          sz;
    stage_state_e es;
    for (int i = 0; i < N; i++) begin
      up_valid[i] = (src[i].size() > 0);
      up_data[i]  = (src[i].size() > 0) ? src[i][0] : $urandom;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      sz    = mq[i].size();
      er[i] = (cap[i] == 2) ? (sz < 2) : ((sz == 0) || down_ready[i]);
      if (do_chk) begin
        chk_eq($sformatf("up_ready[%0d]", i), 32'(up_ready[i]), 32'(er[i]));
        chk_eq($sformatf("down_valid[%0d]", i), 32'(down_valid[i]), 32'(sz > 0));
        if (sz > 0) chk_eq($sformatf("down_data[%0d]", i), down_data[i], mq[i][0]);
        chk_eq($sformatf("stall_cnt[%0d]", i), 32'(st[i]), 32'(mst[i]));
        if (cap[i] == 2) begin
          es = (sz == 2) ? ST_SKID : (sz == 1) ? ST_FULL : ST_EMPTY;
          chk_eq($sformatf("state[%0d]", i),
                 32'(stage_state(down_valid[i], !up_ready[i])), 32'(es));
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      fu = up_valid[i] && er[i];
      fd = (mq[i].size() > 0) && down_ready[i];
      if (fu) void'(src[i].pop_front());
      if (rst) begin
        mq[i].delete();
        mst[i] = 0;
      end else begin
        if (clr_stats[i]) mst[i] = 0;
        else if ((mq[i].size() > 0) && !down_ready[i] && !flush[i] && (mst[i] < mx[i])) mst[i]++;
        if (fd) void'(mq[i].pop_front());
        if (flush[i]) begin
          mq[i].delete();
          src[i].delete();
        end else if (fu) begin
          mq[i].push_back(up_data[i]);
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_all(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      mst[i] = 0;
      repeat (3) src[i].push_back(32'hAAAA_AAAA);
    end

    // Reset with upstream presenting data: nothing may be captured.
    step(1'b0);
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    step(1'b1);
    step(1'b1);

    // Streaming at full rate.
    set_all(1'b1, 1'b0, 1'b0);
    for (int v = 1; v <= 8; v++) push_all(32'(v));
    repeat (10) step(1'b1);

    // Backpressure into the skid entry, then release.
    set_all(1'b0, 1'b0, 1'b0);
    push_all(32'h10); push_all(32'h11); push_all(32'h12);
    repeat (4) step(1'b1);
    set_all(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1);

    // Flush while full with a new word offered.
    set_all(1'b0, 1'b0, 1'b0);
    push_all(32'h20); push_all(32'h21); push_all(32'h22);
    repeat (3) step(1'b1);
    set_all(1'b0, 1'b1, 1'b0);
    step(1'b1);
    set_all(1'b1, 1'b0, 1'b0);
    push_all(32'h23);
    repeat (4) step(1'b1);

    // Stall counter saturation and clear.
    set_all(1'b0, 1'b0, 1'b0);
    push_all(32'h40);
    repeat (21) step(1'b1);
    chk_eq("sat_small", 32'(st[2]), 32'd15);
    set_all(1'b0, 1'b0, 1'b1);
    step(1'b1);
    set_all(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1);
    set_all(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1);

    // Toggling down_ready, mainly for the single-register variant.
    push_all(32'h30); push_all(32'h31);
    for (int k = 0; k < 8; k++) begin
      set_all(k[0], 1'b0, 1'b0);
      step(1'b1);
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((src[i].size() < 4) && ($urandom_range(0, 99) < 60)) src[i].push_back($urandom);
        down_ready[i] = ($urandom_range(0, 99) < 65);
      end
      begin
        logic fl, cl;
        fl = ($urandom_range(0, 99) < 3);
        cl = ($urandom_range(0, 99) < 3);
        for (int i = 0; i < N; i++) begin
          flush[i]     = fl;
          clr_stats[i] = cl;
        end
      end
      step(1'b1);
    end

    // Drain: every accepted word must come out within a bounded time.
    set_all(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) begin
      step(1'b1);
    end
    for (int i = 0; i < N; i++) begin
      chk_eq($sformatf("drain_src[%0d]", i), 32'(src[i].size()), 32'd0);
      chk_eq($sformatf("drain_vld[%0d]", i), 32'(down_valid[i]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline stage register for the core's inter-stage payloads (decode, execute, memory and writeback signal structs, flattened).
- Replaces bare per-stage flops with a valid/ready handshake, a 2-entry skid buffer for full throughput with registered upstream ready, and a synchronous flush for branch/jump redirect.
- Counts downstream-stall cycles for performance analysis.
- Sits between adjacent core stages, one instance per stage boundary.

Parameters:
WIDTH, 32, payload width in bits (set to the width of the stage struct being carried).
SKID, 1, 1 = 2-entry skid buffer with registered up_ready; 0 = single register with combinational up_ready.
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  input  1  core clock.
rst  input  1  reset: one clock, reset is synchronous and active-high.
flush  input  1  drop all held entries; synchronous.
up_valid  input  1  upstream has a payload.
up_ready  output  1  stage can accept a payload.
up_data  input  WIDTH  upstream payload.
down_valid  output  1  stage presents a payload.
down_ready  input  1  downstream accepts the payload.
down_data  output  WIDTH  payload to downstream; always the oldest held entry.
clr_stats  input  1  clear the stall counter.
stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Transfers: up_fire = up_valid & up_ready; down_fire = down_valid & down_ready; both sampled at the rising edge of clk.
- Reset values:
  - Internal valids (main_v, skid_v) are 0, so down_valid = 0 and stall_cnt = 0.
  - up_ready is 1 during and after reset, but any up_fire in a rst cycle is discarded.
  - Payload registers are not reset; down_data is don't-care while down_valid = 0.
- Priority: rst > flush > normal operation.
- flush:
  - Next cycle main_v = skid_v = 0.
  - An up_fire in the flush cycle is discarded.
  - A down_fire in the flush cycle still counts as delivered downstream; the stage neither blocks it nor replays it.
- Latency: 1 cycle from up_fire into an empty stage to down_valid = 1. Payloads are delivered strictly in acceptance order, with no loss or duplication.
- SKID=1 state machine (state is encoded by main_v and skid_v):
  - EMPTY:
    - up_fire -> FULL, main <= up_data.
  - FULL:
    - up_fire & down_ready -> FULL, main <= up_data.
    - up_fire & !down_ready -> SKID, skid <= up_data.
    - !up_fire & down_ready -> EMPTY.
    - otherwise hold.
  - SKID:
    - up_ready = 0.
    - down_ready -> FULL, main <= skid.
    - otherwise hold.
  - up_ready = !skid_v, driven directly from a flop with no combinational path from down_ready.
  - Sustains 1 transfer/cycle when down_ready is held high.
- SKID=0:
  - up_ready = !main_v | down_ready (combinational).
  - States are EMPTY/FULL only; a simultaneous up_fire & down_fire replaces main.
  - The skid register must not be synthesised.
- Stall counter:
  - Increments when down_valid & !down_ready & !flush.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - clr_stats forces 0 next cycle and has priority over increment.
- Protocol rules:
  - Once down_valid = 1, down_valid and down_data stay stable until down_fire or flush.
  - down_valid never depends combinationally on up_valid.

Decomposition:
- Package pipeline additions:
  - localparam STAGE_CNT_W = 16.
  - typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_e, used by the implementation and by bench assertions.
  - The existing stage structs are carried as WIDTH = $bits(struct).
- Sub-module: sat_counter, parametrised by width, with inc and clr inputs. It is natural and reusable for other perf counters. No other sub-modules.

Test Plan:
- Reset/empty: rst high for 3 cycles with up_valid = 1 and up_data = 0xAAAA_AAAA -> after rst falls, down_valid = 0, stall_cnt = 0, up_ready = 1, and nothing is delivered.
- Streaming: SKID=1, down_ready = 1, push 0x1..0x8 on consecutive cycles -> down_data = 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first push, with up_ready constantly 1.
- Backpressure/skid: push 0x10, 0x11, 0x12 with down_ready = 0 -> up_ready falls after 0x11 is accepted and 0x12 is held upstream. Raise down_ready -> 0x10, 0x11, 0x12 delivered in order, and stall_cnt equals the number of stalled cycles.
- Flush: hold stage in SKID (0x20, 0x21), assert flush with up_valid = 1 and up_data = 0x22 -> next cycle down_valid = 0 and 0x22 is never delivered. The next push 0x23 emerges normally.
- Counter saturation/clear: CNT_W = 4, down_valid = 1, down_ready = 0 for 20 cycles -> stall_cnt stops at 15. Pulse clr_stats -> 0 next cycle, then resumes counting at 1.
- SKID=0: push 0x30 and 0x31 with down_ready toggling 0,1,0,1 -> up_ready = !main_v | down_ready every cycle, and both words are delivered once, in order.
